// File: rtl/tqvp_ofdm_mapper_pkg.sv
// Shared encodings and mapping helpers for the OFDM constellation mapper.
// Holds mode/state enums, the register map and the Gray-to-level tables.
package ofdm_map_pkg;

  typedef enum logic [1:0] {
    MODE_BPSK  = 2'd0,
    MODE_QPSK  = 2'd1,
    MODE_16QAM = 2'd2,
    MODE_64QAM = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_MAP   = 2'd2,
    ST_FLUSH = 2'd3
  } state_t;

  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_IN     = 4'h2;
  localparam logic [3:0] ADDR_SYM    = 4'h3;
  localparam logic [3:0] ADDR_I      = 4'h4;
  localparam logic [3:0] ADDR_Q      = 4'h5;
  localparam logic [3:0] ADDR_POP    = 4'h6;
  localparam logic [3:0] ADDR_OCNT   = 4'h7;
  localparam logic [3:0] ADDR_CLR    = 4'h8;

  function automatic logic [2:0] bits_per_sym(mode_t m);
    logic [2:0] b;
    b = 3'd1;
    case (m)
      MODE_BPSK:  b = 3'd1;
      MODE_QPSK:  b = 3'd2;
      MODE_16QAM: b = 3'd4;
      MODE_64QAM: b = 3'd6;
      default:    b = 3'd1;
    endcase
    return b;
  endfunction

  // k is the number of bits on this axis; b[k-1] is the MSB of the Gray code.
  function automatic logic signed [3:0] gray_level(logic [2:0] b, logic [1:0] k);
    logic signed [3:0] lvl;
    lvl = 4'sd0;
    case (k)
      2'd1: lvl = b[0] ? -4'sd1 : 4'sd1;
      2'd2: begin
        case (b[1:0])
          2'b00:   lvl = -4'sd3;
          2'b01:   lvl = -4'sd1;
          2'b11:   lvl = 4'sd1;
          default: lvl = 4'sd3;
        endcase
      end
      default: begin
        case (b)
          3'b000:  lvl = -4'sd7;
          3'b001:  lvl = -4'sd5;
          3'b011:  lvl = -4'sd3;
          3'b010:  lvl = -4'sd1;
          3'b110:  lvl = 4'sd1;
          3'b111:  lvl = 4'sd3;
          3'b101:  lvl = 4'sd5;
          default: lvl = 4'sd7;
        endcase
      end
    endcase
    return lvl;
  endfunction

  // Returns {Q[3:0], I[3:0]} for the symbol bits b (b[0] consumed first).
  function automatic logic [7:0] map_symbol(mode_t m, logic [5:0] b);
    logic signed [3:0] i_lvl;
    logic signed [3:0] q_lvl;
    i_lvl = 4'sd0;
    q_lvl = 4'sd0;
    case (m)
      MODE_BPSK: begin
        i_lvl = gray_level({2'b00, b[0]}, 2'd1);
      end
      MODE_QPSK: begin
        i_lvl = gray_level({2'b00, b[0]}, 2'd1);
        q_lvl = gray_level({2'b00, b[1]}, 2'd1);
      end
      MODE_16QAM: begin
        i_lvl = gray_level({1'b0, b[1:0]}, 2'd2);
        q_lvl = gray_level({1'b0, b[3:2]}, 2'd2);
      end
      default: begin
        i_lvl = gray_level(b[2:0], 2'd3);
        q_lvl = gray_level(b[5:3], 2'd3);
      end
    endcase
    return {q_lvl, i_lvl};
  endfunction

endpackage

// File: rtl/tqvp_ofdm_mapper_if.sv
// TinyQV peripheral register bus. A write happens in every cycle data_write is
// high (no ready/back-pressure); data_out is combinational on address.
interface tqvp_ofdm_mapper_if;
  logic [3:0] address;
  logic       data_write;
  logic [7:0] data_in;
  logic [7:0] data_out;

  modport master (output address, output data_write, output data_in, input data_out);
  modport slave  (input address, input data_write, input data_in, output data_out);
endinterface

// File: rtl/tqvp_ofdm_mapper_sync_fifo.sv
// Single-clock FIFO with occupancy count. Push when full and pop when empty
// are ignored; both decisions use the pre-cycle occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tqvp_ofdm_mapper.sv
// OFDM constellation mapper peripheral: byte FIFO -> bit accumulator -> Gray
// mapper -> symbol FIFO, with an IDLE/LOAD/MAP/FLUSH sequencer.
module tqvp_ofdm_mapper
  import ofdm_map_pkg::*;
#(
  parameter int IQ_W      = 4,
  parameter int IN_DEPTH  = 4,
  parameter int OUT_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               ui_in,
  output logic [7:0]               uo_out,
  tqvp_ofdm_mapper_if.slave        bus
);
  localparam int IW = $clog2(IN_DEPTH) + 1;
  localparam int OW = $clog2(OUT_DEPTH) + 1;
  localparam int SW = 2 * IQ_W;

  logic   enable;
  mode_t  mode_reg;
  mode_t  mode_q;
  logic   flush_p;
  logic   ovf;
  logic   udf;
  state_t state;
  logic [15:0] acc;
  logic [3:0]  cnt;

  logic wr_ctrl, soft_clr, bus_push, bus_pop, w1c;
  assign wr_ctrl  = bus.data_write && (bus.address == ADDR_CTRL);
  assign soft_clr = wr_ctrl && bus.data_in[4];
  assign bus_push = bus.data_write && (bus.address == ADDR_IN);
  assign bus_pop  = bus.data_write && (bus.address == ADDR_POP);
  assign w1c      = bus.data_write && (bus.address == ADDR_CLR);

  logic [7:0]    in_head;
  logic [IW-1:0] in_count;
  logic          in_full, in_empty, in_pop;
  logic [SW-1:0] out_head, out_wdata;
  logic [OW-1:0] out_count;
  logic          out_full, out_empty, emit;

  assign in_pop = (state == ST_LOAD);
  // out_full is the registered occupancy, so a same-cycle pop never frees a slot early.
  assign emit   = !out_full && ((state == ST_MAP) || (state == ST_FLUSH));

  sync_fifo #(.WIDTH(8), .DEPTH(IN_DEPTH)) u_in_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (soft_clr),
    .push  (bus_push),
    .wdata (bus.data_in),
    .pop   (in_pop),
    .rdata (in_head),
    .count (in_count),
    .full  (in_full),
    .empty (in_empty)
  );

  sync_fifo #(.WIDTH(SW), .DEPTH(OUT_DEPTH)) u_out_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (soft_clr),
    .push  (emit),
    .wdata (out_wdata),
    .pop   (bus_pop),
    .rdata (out_head),
    .count (out_count),
    .full  (out_full),
    .empty (out_empty)
  );

  // Bits above the live count are always zero, so flush padding comes for free.
  logic [7:0]             sym4;
  logic signed [3:0]      lvl_i, lvl_q;
  logic signed [IQ_W-1:0] ext_i, ext_q;
  assign sym4      = map_symbol(mode_q, acc[5:0]);
  assign lvl_i     = sym4[3:0];
  assign lvl_q     = sym4[7:4];
  assign ext_i     = IQ_W'(lvl_i);
  assign ext_q     = IQ_W'(lvl_q);
  assign out_wdata = {ext_q, ext_i};

  logic [3:0] b_idle, b_act, cnt_load, cnt_after;
  assign b_idle    = {1'b0, bits_per_sym(mode_reg)};
  assign b_act     = {1'b0, bits_per_sym(mode_q)};
  assign cnt_load  = cnt + 4'd8;
  assign cnt_after = cnt - b_act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cnt    <= '0;
      mode_q <= MODE_BPSK;
    end else if (soft_clr) begin
      state  <= ST_IDLE;
      acc    <= '0;
      cnt    <= '0;
      mode_q <= MODE_BPSK;
    end else begin
      case (state)
        ST_IDLE: begin
          if (enable && (cnt >= b_idle)) begin
            state  <= ST_MAP;
            mode_q <= mode_reg;
          end else if (enable && !in_empty) begin
            state  <= ST_LOAD;
            mode_q <= mode_reg;
          end else if (flush_p && (cnt != 4'd0)) begin
            state  <= ST_FLUSH;
            mode_q <= mode_reg;
          end
        end
        ST_LOAD: begin
          acc   <= acc | ({8'h00, in_head} << cnt);
          cnt   <= cnt_load;
          state <= (cnt_load >= b_act) ? ST_MAP : ST_IDLE;
        end
        ST_MAP: begin
          if (!out_full) begin
            acc <= acc >> b_act;
            cnt <= cnt_after;
            if ((cnt_after < b_act) || !enable) state <= ST_IDLE;
          end
        end
        default: begin
          if (!out_full) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable   <= 1'b0;
      mode_reg <= MODE_BPSK;
      flush_p  <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else if (soft_clr) begin
      enable   <= 1'b0;
      mode_reg <= MODE_BPSK;
      flush_p  <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
    end else begin
      flush_p <= wr_ctrl && bus.data_in[3];
      if (wr_ctrl) begin
        enable   <= bus.data_in[0];
        mode_reg <= mode_t'(bus.data_in[2:1]);
      end
      if (bus_push && in_full)         ovf <= 1'b1;
      else if (w1c && bus.data_in[4])  ovf <= 1'b0;
      if (bus_pop && out_empty)        udf <= 1'b1;
      else if (w1c && bus.data_in[5])  udf <= 1'b0;
    end
  end

  logic signed [IQ_W-1:0] head_i, head_q;
  assign head_i = out_head[IQ_W-1:0];
  assign head_q = out_head[SW-1:IQ_W];

  logic [7:0] rdata;
  always_comb begin
    rdata = 8'h00;
    case (bus.address)
      ADDR_CTRL:   rdata = {5'b00000, mode_reg, enable};
      ADDR_STATUS: rdata = {state, udf, ovf, out_empty, out_full, in_empty, in_full};
      ADDR_IN:     rdata = 8'(in_count);
      ADDR_SYM:    rdata = out_empty ? 8'h00 : {head_q[3:0], head_i[3:0]};
      ADDR_I:      rdata = out_empty ? 8'h00 : 8'(head_i);
      ADDR_Q:      rdata = out_empty ? 8'h00 : 8'(head_q);
      ADDR_OCNT:   rdata = 8'(out_count);
      default:     rdata = 8'h00;
    endcase
  end
  assign bus.data_out = rdata;

  // Bit 0 is the UART TX pin on the host and must stay low.
  assign uo_out = {4'b0000, out_full, !out_empty, (state != ST_IDLE), 1'b0};

  logic unused_ok;
  assign unused_ok = &{1'b0, ui_in};
endmodule

// File: tb/tb_tqvp_ofdm_mapper.sv
// Bench for tqvp_ofdm_mapper: directed scenarios plus randomized payloads,
// checked against a bit-queue model of the mapping rules.
module tb_tqvp_ofdm_mapper;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  tqvp_ofdm_mapper_if bus ();

  tqvp_ofdm_mapper dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int         n_cmp;
  int         n_bad;
  logic [7:0] exp_q[$];
  bit         mbits[$];
  int         m_mode;

  // ---------------- reference model ----------------
  function automatic int ref_level(int k, int g);
    int bin;
    if (k == 1) return (g != 0) ? -1 : 1;
    bin = g ^ (g >> 1) ^ (g >> 2);
    return 2 * bin - ((1 << k) - 1);
  endfunction

  function automatic int bits_of(int mode);
    return (mode == 0) ? 1 : (mode == 1) ? 2 : (mode == 2) ? 4 : 6;
  endfunction

  function automatic logic [7:0] ref_symbol(int mode, int v);
    int k, iv, qv;
    logic [3:0] i4, q4;
    k  = (mode <= 1) ? 1 : (mode == 2) ? 2 : 3;
    iv = ref_level(k, v & ((1 << k) - 1));
    qv = (mode == 0) ? 0 : ref_level(k, (v >> k) & ((1 << k) - 1));
    i4 = 4'(iv);
    q4 = 4'(qv);
    return {q4, i4};
  endfunction

  task automatic model_push(input logic [7:0] b);
    int v;
    for (int j = 0; j < 8; j++) mbits.push_back(b[j]);
    while (mbits.size() >= bits_of(m_mode)) begin
      v = 0;
      for (int j = 0; j < bits_of(m_mode); j++) v |= int'(mbits.pop_front()) << j;
      exp_q.push_back(ref_symbol(m_mode, v));
    end
  endtask

  task automatic model_flush();
    int v;
    int n;
    if (mbits.size() > 0) begin
      v = 0;
      n = mbits.size();
      for (int j = 0; j < n; j++) v |= int'(mbits.pop_front()) << j;
      exp_q.push_back(ref_symbol(m_mode, v));
    end
  endtask

  // ---------------- bus driver tasks ----------------
  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.data_in    = d;
    bus.data_write = 1'b1;
    @(posedge clk);
    #1;
    bus.data_write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk);
    bus.address = a;
    #1;
    d = bus.data_out;
  endtask

  task automatic pop_symbol(output logic [7:0] sym, output logic [7:0] iv,
                            output logic [7:0] qv, output bit to);
    logic [7:0] c;
    to  = 1'b1;
    sym = 8'h00;
    iv  = 8'h00;
    qv  = 8'h00;
    for (int w = 0; w < 300; w++) begin
      bus_read(4'h7, c);
      if (c != 8'h00) begin
        to = 1'b0;
        break;
      end
    end
    if (!to) begin
      bus_read(4'h3, sym);
      bus_read(4'h4, iv);
      bus_read(4'h5, qv);
      bus_write(4'h6, 8'h00);
    end
  endtask

  task automatic wait_idle(output bit to);
    logic [7:0] s;
    to = 1'b1;
    for (int w = 0; w < 300; w++) begin
      bus_read(4'h1, s);
      if (s[7:6] == 2'd0 && s[1]) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [3:0] addrs[9];
    logic [7:0] exps[9];
    logic [7:0] d;
    addrs = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h0, 4'hC};
    exps  = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (uo_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_uo_in_reset: got %02h expected 00", uo_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus_read(addrs[k], d);
      n_cmp++;
      if (d !== exps[k]) begin
        n_bad++;
        $display("FAIL reset_read_%0h: got %02h expected %02h", addrs[k], d, exps[k]);
      end
    end
    n_cmp++;
    if (uo_out !== 8'h00) begin
      n_bad++;
      $display("FAIL reset_uo: got %02h expected 00", uo_out);
    end
  endtask

  task automatic test_qpsk();
    logic [7:0] sym, iv, qv, e, d;
    bit to;
    bus_write(4'h0, 8'h03);
    bus_read(4'h0, d);
    n_cmp++;
    if (d !== 8'h03) begin
      n_bad++;
      $display("FAIL qpsk_ctrl_readback: got %02h expected 03", d);
    end
    m_mode = 1;
    model_push(8'hE4);
    bus_write(4'h2, 8'hE4);
    for (int n = 0; n < 4; n++) begin
      e = exp_q.pop_front();
      pop_symbol(sym, iv, qv, to);
      n_cmp++;
      if (to || sym !== e || iv !== {{4{e[3]}}, e[3:0]} || qv !== {{4{e[7]}}, e[7:4]}) begin
        n_bad++;
        $display("FAIL qpsk_sym%0d: got sym=%02h i=%02h q=%02h timeout=%0d expected sym=%02h",
                 n, sym, iv, qv, to, e);
      end
    end
    bus_read(4'h1, d);
    n_cmp++;
    if (d[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL qpsk_out_empty: got status %02h expected bit3 set", d);
    end
  endtask

  task automatic test_16qam();
    logic [7:0] sym, iv, qv, e;
    bit to;
    bus_write(4'h0, 8'h05);
    m_mode = 2;
    model_push(8'h5A);
    bus_write(4'h2, 8'h5A);
    for (int n = 0; n < 2; n++) begin
      e = exp_q.pop_front();
      pop_symbol(sym, iv, qv, to);
      n_cmp++;
      if (to || sym !== e || iv !== {{4{e[3]}}, e[3:0]} || qv !== {{4{e[7]}}, e[7:4]}) begin
        n_bad++;
        $display("FAIL qam16_sym%0d: got sym=%02h i=%02h q=%02h timeout=%0d expected sym=%02h",
                 n, sym, iv, qv, to, e);
      end
    end
  endtask

  task automatic test_64qam_straddle();
    logic [7:0] sym, iv, qv, e, d;
    logic [7:0] seq[3];
    bit to;
    seq = '{8'h00, 8'hFF, 8'h00};
    bus_write(4'h0, 8'h07);
    m_mode = 3;
    for (int step = 0; step < 5; step++) begin
      if (step == 0 || step == 1 || step == 3) begin
        model_push(seq[step == 3 ? 2 : step]);
        bus_write(4'h2, seq[step == 3 ? 2 : step]);
      end else begin
        wait_idle(to);
        n_cmp++;
        if (to) begin
          n_bad++;
          $display("FAIL qam64_idle_before_flush%0d: got timeout expected idle", step);
        end
        model_flush();
        bus_write(4'h0, 8'h0F);
      end
      e = exp_q.pop_front();
      pop_symbol(sym, iv, qv, to);
      n_cmp++;
      if (to || sym !== e || iv !== {{4{e[3]}}, e[3:0]} || qv !== {{4{e[7]}}, e[7:4]}) begin
        n_bad++;
        $display("FAIL qam64_step%0d: got sym=%02h i=%02h q=%02h timeout=%0d expected sym=%02h",
                 step, sym, iv, qv, to, e);
      end
    end
    bus_read(4'h0, d);
    n_cmp++;
    if (d !== 8'h07) begin
      n_bad++;
      $display("FAIL qam64_flush_selfclear: got ctrl %02h expected 07", d);
    end
    repeat (4) @(posedge clk);
    bus_read(4'h1, d);
    n_cmp++;
    if (d !== 8'h0A) begin
      n_bad++;
      $display("FAIL qam64_final_status: got %02h expected 0A", d);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] d;
    bus_write(4'h0, 8'h10);
    exp_q.delete();
    mbits.delete();
    bus_write(4'h0, 8'h01);
    m_mode = 0;
    model_push(8'hFF);
    model_push(8'h00);
    bus_write(4'h2, 8'hFF);
    bus_write(4'h2, 8'h00);
    repeat (40) @(posedge clk);
    bus_read(4'h7, d);
    n_cmp++;
    if (d !== 8'h08) begin
      n_bad++;
      $display("FAIL bp_out_count: got %02h expected 08", d);
    end
    bus_read(4'h1, d);
    n_cmp++;
    if (d !== 8'h86) begin
      n_bad++;
      $display("FAIL bp_status_stalled: got %02h expected 86", d);
    end
    n_cmp++;
    if (uo_out !== 8'h0E) begin
      n_bad++;
      $display("FAIL bp_uo: got %02h expected 0E", uo_out);
    end
    bus_read(4'h3, d);
    n_cmp++;
    if (d !== exp_q[0]) begin
      n_bad++;
      $display("FAIL bp_head: got %02h expected %02h", d, exp_q[0]);
    end
    bus_write(4'h6, 8'h00);
    void'(exp_q.pop_front());
    bus_read(4'h7, d);
    n_cmp++;
    if (d !== 8'h07) begin
      n_bad++;
      $display("FAIL bp_count_after_pop: got %02h expected 07", d);
    end
    bus_read(4'h7, d);
    n_cmp++;
    if (d !== 8'h08) begin
      n_bad++;
      $display("FAIL bp_refill_next_cycle: got %02h expected 08", d);
    end
    bus_read(4'h3, d);
    n_cmp++;
    if (d !== exp_q[0]) begin
      n_bad++;
      $display("FAIL bp_head_after_pop: got %02h expected %02h", d, exp_q[0]);
    end
    bus_write(4'h0, 8'h10);
    exp_q.delete();
    mbits.delete();
    bus_read(4'h1, d);
    n_cmp++;
    if (d !== 8'h0A) begin
      n_bad++;
      $display("FAIL bp_soft_clear_status: got %02h expected 0A", d);
    end
    bus_read(4'h7, d);
    n_cmp++;
    if (d !== 8'h00 || uo_out !== 8'h00) begin
      n_bad++;
      $display("FAIL bp_soft_clear_outputs: got count %02h uo %02h expected 00 00", d, uo_out);
    end
  endtask

  task automatic test_errors();
    logic [7:0] pend[$];
    logic [7:0] b, d, sym, iv, qv, e;
    bit to;
    int n;
    bus_write(4'h0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      b = 8'($urandom_range(0, 255));
      if (k < 4) pend.push_back(b);
      bus_write(4'h2, b);
    end
    bus_read(4'h2, d);
    n_cmp++;
    if (d !== 8'h04) begin
      n_bad++;
      $display("FAIL err_in_count: got %02h expected 04", d);
    end
    bus_read(4'h1, d);
    n_cmp++;
    if (d !== 8'h19) begin
      n_bad++;
      $display("FAIL err_overflow: got status %02h expected 19", d);
    end
    bus_write(4'h6, 8'h00);
    bus_read(4'h1, d);
    n_cmp++;
    if (d !== 8'h39) begin
      n_bad++;
      $display("FAIL err_underflow: got status %02h expected 39", d);
    end
    bus_write(4'h8, 8'h30);
    bus_read(4'h1, d);
    n_cmp++;
    if (d !== 8'h09) begin
      n_bad++;
      $display("FAIL err_w1c: got status %02h expected 09", d);
    end
    m_mode = 1;
    foreach (pend[k]) model_push(pend[k]);
    bus_write(4'h0, 8'h03);
    n = exp_q.size();
    for (int k = 0; k < n; k++) begin
      e = exp_q.pop_front();
      pop_symbol(sym, iv, qv, to);
      n_cmp++;
      if (to || sym !== e || iv !== {{4{e[3]}}, e[3:0]} || qv !== {{4{e[7]}}, e[7:4]}) begin
        n_bad++;
        $display("FAIL err_drain_sym%0d: got sym=%02h i=%02h q=%02h timeout=%0d expected sym=%02h",
                 k, sym, iv, qv, to, e);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] b, d, sym, iv, qv, e, ctrl;
    bit to;
    int n, nb;
    bus_write(4'h0, 8'h10);
    exp_q.delete();
    mbits.delete();
    for (int r = 0; r < 8; r++) begin
      m_mode = $urandom_range(0, 3);
      ctrl   = 8'(1 | (m_mode << 1));
      bus_write(4'h0, ctrl);
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        b = 8'($urandom_range(0, 255));
        model_push(b);
        bus_write(4'h2, b);
        repeat ($urandom_range(0, 3)) @(posedge clk);
      end
      for (int pass = 0; pass < 2; pass++) begin
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
          e = exp_q.pop_front();
          pop_symbol(sym, iv, qv, to);
          n_cmp++;
          if (to || sym !== e || iv !== {{4{e[3]}}, e[3:0]} || qv !== {{4{e[7]}}, e[7:4]}) begin
            n_bad++;
            $display("FAIL rand_r%0d_p%0d_sym%0d mode=%0d: got sym=%02h i=%02h q=%02h timeout=%0d expected sym=%02h",
                     r, pass, k, m_mode, sym, iv, qv, to, e);
          end
        end
        if (pass == 0) begin
          wait_idle(to);
          n_cmp++;
          if (to) begin
            n_bad++;
            $display("FAIL rand_r%0d_idle: got timeout expected idle", r);
          end
          model_flush();
          bus_write(4'h0, ctrl | 8'h08);
        end
      end
      repeat (5) @(posedge clk);
      bus_read(4'h7, d);
      n_cmp++;
      if (d !== 8'h00) begin
        n_bad++;
        $display("FAIL rand_r%0d_leftover: got out count %02h expected 00", r, d);
      end
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    m_mode         = 0;
    ui_in          = 8'($urandom);
    bus.address    = 4'h0;
    bus.data_in    = 8'h00;
    bus.data_write = 1'b0;
    rst_n          = 1'b0;
    test_reset();
    test_qpsk();
    test_16qam();
    test_64qam_straddle();
    test_backpressure();
    test_errors();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "watchdog");
  end
endmodule
